// File: rtl/sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_N_IN   = 2;
  localparam int DEFAULT_SETTLE = 1;

  function automatic int table_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Counts the cycles a vector has been held; tick marks the SETTLE-th cycle after clear.
module settle_timer
  import sweeper_pkg::*;
#(
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The counter restarts on its own after each tick so consecutive vectors get equal hold times.
  always_comb begin
    tick    = !clear && (count_q == LAST);
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination in ascending order, captures the function output after
// a settle time, and compares the captured truth table against a latched expected mask.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN   = DEFAULT_N_IN,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [table_width(N_IN)-1:0]  expected,
  output logic [N_IN-1:0]               vec,
  input  logic                          s_in,
  output logic                          busy,
  output logic                          done,
  output logic [table_width(N_IN)-1:0]  table_out,
  output logic                          match
);

  localparam int W = table_width(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          state_q, state_d;
  logic [N_IN-1:0] index_q, index_d;
  logic [W-1:0]    table_q, table_d;
  logic [W-1:0]    exp_q,   exp_d;
  logic            match_q, match_d;
  logic            tick;

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != DRIVE),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      table_q <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      table_q <= table_d;
      exp_q   <= exp_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (tick && (index_q == LAST_IDX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // match is resolved on the final sample edge so it is already valid while done is high.
  always_comb begin
    index_d = index_q;
    table_d = table_q;
    exp_d   = exp_q;
    match_d = match_q;
    if ((state_q == IDLE) && start) begin
      index_d = '0;
      table_d = '0;
      exp_d   = expected;
      match_d = 1'b0;
    end else if ((state_q == DRIVE) && tick) begin
      table_d[index_q] = s_in;
      if (index_q == LAST_IDX) begin
        match_d = (table_d == exp_q);
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  always_comb begin
    busy      = (state_q == DRIVE);
    done      = (state_q == DONE);
    vec       = (state_q == DRIVE) ? index_q : '0;
    table_out = table_q;
    match     = match_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised sweeps on two sweeper instances (SETTLE=1 and SETTLE=3) checked against a
// cycle-count model of the expected vector sequence, capture and compare result.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [3:0] exp_a, exp_b;
  logic [3:0] func_a, func_b;
  logic [1:0] vec_a, vec_b;
  logic       s_in_a, s_in_b;
  logic       busy_a, busy_b, done_a, done_b, match_a, match_b;
  logic [3:0] table_a, table_b;
  logic       garb_en, garb_bit;

  int checks   = 0;
  int failures = 0;

  logic [1:0] ov;
  logic       ob, od, om;
  logic [3:0] ot;

  always #5 clk = ~clk;

  // The function under test is its own truth table; garbage models glitches off sample edges.
  assign s_in_a = garb_en ? garb_bit : func_a[vec_a];
  assign s_in_b = garb_en ? garb_bit : func_b[vec_b];

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .expected(exp_a), .vec(vec_a),
    .s_in(s_in_a), .busy(busy_a), .done(done_a), .table_out(table_a), .match(match_a)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .expected(exp_b), .vec(vec_b),
    .s_in(s_in_b), .busy(busy_b), .done(done_b), .table_out(table_b), .match(match_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic observe(input int which);
    ov = which != 0 ? vec_b   : vec_a;
    ob = which != 0 ? busy_b  : busy_a;
    od = which != 0 ? done_b  : done_a;
    ot = which != 0 ? table_b : table_a;
    om = which != 0 ? match_b : match_a;
  endtask

  task automatic set_start(input int which, input logic v);
    if (which != 0) start_b = v;
    else            start_a = v;
  endtask

  // mode: 0 plain, 1 extra start pulses mid-sweep and in DONE, 2 glitches, 3 reset at vec=2
  task automatic sweep(input int which, input logic [3:0] func, input logic [3:0] mask,
                       input int mode);
    int s;
    int n;
    s = (which != 0) ? 3 : 1;
    n = 4 * s;
    if (which != 0) begin func_b = func; exp_b = mask; end
    else            begin func_a = func; exp_a = mask; end
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
    for (int t = 0; t < n; t++) begin
      observe(which);
      check("sweep_vec", ov, t / s);
      check("sweep_busy", ob, 1);
      check("sweep_done", od, 0);
      if (mode == 3 && t == 2 * s + 1) begin
        #2 reset = 1'b1;
        #1;
        observe(which);
        check("async_reset_outputs", {ov, ob, od, ot, om}, 0);
        @(negedge clk);
        reset = 1'b0;
        $display("txn dut=%0d func=%h mask=%h mode=%0d aborted", which, func, mask, mode);
        return;
      end
      set_start(which, (mode == 1) && (t == 2 * s));
      garb_en  = (mode == 2) && (((t + 1) % s) != 0);
      garb_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    garb_en = 1'b0;
    observe(which);
    check("done_pulse", od, 1);
    check("done_busy", ob, 0);
    check("done_vec", ov, 0);
    check("table", ot, func);
    check("match", om, func == mask);
    set_start(which, mode == 1);
    @(negedge clk);
    set_start(which, 1'b0);
    observe(which);
    check("post_done", {ob, od}, 0);
    check("table_hold", ot, func);
    check("match_hold", om, func == mask);
    @(negedge clk);
    observe(which);
    check("no_restart", {ob, od}, 0);
    $display("txn dut=%0d func=%h mask=%h mode=%0d table=%h match=%0d",
             which, func, mask, mode, ot, om);
  endtask

  initial begin
    logic [3:0] f;
    logic [3:0] m;
    int seen;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    exp_a = '0; exp_b = '0; func_a = '0; func_b = '0;
    garb_en = 1'b0; garb_bit = 1'b0;
    #1;
    check("reset_a", {vec_a, busy_a, done_a, table_a, match_a}, 0);
    check("reset_b", {vec_b, busy_b, done_b, table_b, match_b}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_a", {vec_a, busy_a, done_a, table_a, match_a}, 0);
      check("idle_b", {vec_b, busy_b, done_b, table_b, match_b}, 0);
    end

    sweep(0, 4'b0000, 4'b0000, 0);   // constant-0 function
    sweep(1, 4'b1000, 4'b1000, 0);   // AND(x,y)
    sweep(1, 4'b1110, 4'b1000, 0);   // OR(x,y) against the AND mask
    sweep(1, 4'b1000, 4'b1000, 1);
    sweep(0, 4'b0110, 4'b0110, 1);
    sweep(1, 4'b0110, 4'b1001, 2);
    sweep(1, 4'b1000, 4'b1000, 3);
    sweep(1, 4'b0111, 4'b0111, 0);   // fresh sweep after the reset

    for (int r = 0; r < 8; r++) begin
      f = 4'($urandom);
      m = ($urandom_range(0, 1) != 0) ? f : 4'($urandom);
      sweep(r % 2, f, m, $urandom_range(0, 2));
    end

    // start held high: one IDLE cycle after DONE, then a new sweep begins
    func_a = 4'b1010; exp_a = 4'b1010;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      if (t == 4) check("held_done", {busy_a, done_a, table_a, match_a}, {2'b01, 4'b1010, 1'b1});
      if (t == 5) check("held_idle", {busy_a, done_a}, 0);
      if (t == 6) check("held_restart", {busy_a, vec_a, match_a}, {1'b1, 2'b00, 1'b0});
    end
    start_a = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && seen == 0; t++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    check("held_second_done", seen, 1);
    check("held_second_table", table_a, 4'b1010);
    $display("txn dut=0 held-start func=a mask=a");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
